// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, halt-drain FSM encoding, ID/EX control bundle.
// Also used by the EX/MEM register; keep the control bundle layout stable.
package pipeline_pkg;

  localparam logic [3:0] OP_ATYPE  = 4'b0001;
  localparam logic [3:0] OP_BRANCH = 4'b1000;
  localparam logic [3:0] OP_JUMP   = 4'b1001;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Bubbles loaded after the halt before it is considered retired from WB
  localparam logic [1:0] DRAIN_CNT_INIT = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [3:0] opcode;
    logic [3:0] funct;
    logic [3:0] aluop;
    logic       branch;
    logic       jump;
    logic       halt;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

  function automatic logic starts_drain(input logic valid, input logic halt);
    return valid & halt;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-to-EX bus: stage controls, ID-side instruction fields and registered EX-side copies.
// master = upstream/pipeline side, slave = the ID/EX register.
interface id_ex_stage_reg_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
);
  logic                  stall_i;
  logic                  flush_i;
  logic                  id_valid_i;
  logic [3:0]            id_opcode_i;
  logic [3:0]            id_funct_i;
  logic [3:0]            id_aluop_i;
  logic                  id_branch_i;
  logic                  id_jump_i;
  logic                  id_halt_i;
  logic [DATA_W-1:0]     id_op1_i;
  logic [DATA_W-1:0]     id_op2_i;
  logic [DATA_W-1:0]     id_imm_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic [REG_ADDR_W-1:0] id_rd_i;

  logic                  ex_valid_o;
  logic [3:0]            ex_opcode_o;
  logic [3:0]            ex_funct_o;
  logic [3:0]            ex_aluop_o;
  logic                  ex_branch_o;
  logic                  ex_jump_o;
  logic                  ex_halt_o;
  logic [DATA_W-1:0]     ex_op1_o;
  logic [DATA_W-1:0]     ex_op2_o;
  logic [DATA_W-1:0]     ex_imm_o;
  logic [REG_ADDR_W-1:0] ex_rs1_o;
  logic [REG_ADDR_W-1:0] ex_rs2_o;
  logic [REG_ADDR_W-1:0] ex_rd_o;
  logic                  draining_o;
  logic                  halted_o;

  modport master (
    output stall_i, flush_i, id_valid_i, id_opcode_i, id_funct_i, id_aluop_i,
           id_branch_i, id_jump_i, id_halt_i, id_op1_i, id_op2_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i,
    input  ex_valid_o, ex_opcode_o, ex_funct_o, ex_aluop_o, ex_branch_o,
           ex_jump_o, ex_halt_o, ex_op1_o, ex_op2_o, ex_imm_o, ex_rs1_o,
           ex_rs2_o, ex_rd_o, draining_o, halted_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i, id_opcode_i, id_funct_i, id_aluop_i,
           id_branch_i, id_jump_i, id_halt_i, id_op1_i, id_op2_i, id_imm_i,
           id_rs1_i, id_rs2_i, id_rd_i,
    output ex_valid_o, ex_opcode_o, ex_funct_o, ex_aluop_o, ex_branch_o,
           ex_jump_o, ex_halt_o, ex_op1_o, ex_op2_o, ex_imm_o, ex_rs1_o,
           ex_rs2_o, ex_rd_o, draining_o, halted_o
  );

endinterface

// File: rtl/halt_drain_fsm.sv
// Halt-drain sequencer: RUN -> DRAIN (2 more bubble edges) -> HALTED, terminal until reset.
// Outputs decode the state register directly, so they are glitch-free and registered.
module halt_drain_fsm
  import pipeline_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load_halt,
  output logic o_draining,
  output logic o_halted,
  output logic o_force_bubble
);

  logic [1:0] r_state;
  logic [1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_load_halt) begin
            r_state <= ST_DRAIN;
            r_cnt   <= DRAIN_CNT_INIT;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == 2'd0) r_state <= ST_HALTED;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_HALTED;
      endcase
    end
  end

  assign o_draining     = (r_state == ST_DRAIN);
  assign o_halted       = (r_state == ST_HALTED);
  assign o_force_bubble = (r_state != ST_RUN);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion and halt drain; 1-cycle latency, stall holds.
// Optional flush-bubble counter on flush_cnt_o when ID_EX_FLUSH_CNT_EN is defined.
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_stage_reg_if.slave  bus
`ifdef ID_EX_FLUSH_CNT_EN
  ,
  output logic [15:0]       flush_cnt_o
`endif
);

  id_ex_ctrl_t           r_ctrl;
  logic [DATA_W-1:0]     r_op1;
  logic [DATA_W-1:0]     r_op2;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;

  id_ex_ctrl_t w_id_ctrl;
  logic        w_force_bubble;
  logic        w_bubble;
  logic        w_load;
  logic        w_load_halt;

  assign w_id_ctrl.valid  = bus.id_valid_i;
  assign w_id_ctrl.opcode = bus.id_opcode_i;
  assign w_id_ctrl.funct  = bus.id_funct_i;
  assign w_id_ctrl.aluop  = bus.id_aluop_i;
  assign w_id_ctrl.branch = bus.id_branch_i;
  assign w_id_ctrl.jump   = bus.id_jump_i;
  assign w_id_ctrl.halt   = bus.id_halt_i;

  // Halt state outranks flush, flush outranks stall
  assign w_bubble    = w_force_bubble | bus.flush_i;
  assign w_load      = ~w_bubble & ~bus.stall_i;
  assign w_load_halt = w_load & starts_drain(bus.id_valid_i, bus.id_halt_i);

  halt_drain_fsm u_halt_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load_halt    (w_load_halt),
    .o_draining     (bus.draining_o),
    .o_halted       (bus.halted_o),
    .o_force_bubble (w_force_bubble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= CTRL_BUBBLE;
      r_op1  <= '0;
      r_op2  <= '0;
      r_imm  <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
    end else if (w_bubble) begin
      r_ctrl <= CTRL_BUBBLE;
      r_op1  <= '0;
      r_op2  <= '0;
      r_imm  <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
    end else if (w_load) begin
      r_ctrl <= w_id_ctrl;
      r_op1  <= bus.id_op1_i;
      r_op2  <= bus.id_op2_i;
      r_imm  <= bus.id_imm_i;
      r_rs1  <= bus.id_rs1_i;
      r_rs2  <= bus.id_rs2_i;
      r_rd   <= bus.id_rd_i;
    end
  end

  assign bus.ex_valid_o  = r_ctrl.valid;
  assign bus.ex_opcode_o = r_ctrl.opcode;
  assign bus.ex_funct_o  = r_ctrl.funct;
  assign bus.ex_aluop_o  = r_ctrl.aluop;
  assign bus.ex_branch_o = r_ctrl.branch;
  assign bus.ex_jump_o   = r_ctrl.jump;
  assign bus.ex_halt_o   = r_ctrl.halt;
  assign bus.ex_op1_o    = r_op1;
  assign bus.ex_op2_o    = r_op2;
  assign bus.ex_imm_o    = r_imm;
  assign bus.ex_rs1_o    = r_rs1;
  assign bus.ex_rs2_o    = r_rs2;
  assign bus.ex_rd_o     = r_rd;

`ifdef ID_EX_FLUSH_CNT_EN
  logic [15:0] r_flush_cnt;

  // Counts flushes seen while running, even when the stage is also stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= 16'd0;
    end else if (!w_force_bubble && bus.flush_i && (r_flush_cnt != 16'hFFFF)) begin
      r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed steps plus random traffic against an instruction-level model.
// Counter checks are built only when ID_EX_FLUSH_CNT_EN is defined.
module tb_id_ex_stage_reg;
  import pipeline_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic          valid;
    logic [3:0]    opcode;
    logic [3:0]    funct;
    logic [3:0]    aluop;
    logic          branch;
    logic          jump;
    logic          halt;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

`ifdef ID_EX_FLUSH_CNT_EN
  logic [15:0] flush_cnt;
  int          m_cnt;
`endif

  id_ex_stage_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ID_EX_FLUSH_CNT_EN
    ,
    .flush_cnt_o (flush_cnt)
`endif
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  instr_t id_in;
  logic   stall;
  logic   flush;
  instr_t m_ex;   // what EX should hold
  int     m_age;  // edges since the halt entered EX, -1 when no halt in flight

  task automatic chk(input string tag, input logic [79:0] o, input logic [79:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic instr_t ex_obs();
    instr_t r;
    r.valid  = bus.ex_valid_o;
    r.opcode = bus.ex_opcode_o;
    r.funct  = bus.ex_funct_o;
    r.aluop  = bus.ex_aluop_o;
    r.branch = bus.ex_branch_o;
    r.jump   = bus.ex_jump_o;
    r.halt   = bus.ex_halt_o;
    r.op1    = bus.ex_op1_o;
    r.op2    = bus.ex_op2_o;
    r.imm    = bus.ex_imm_o;
    r.rs1    = bus.ex_rs1_o;
    r.rs2    = bus.ex_rs2_o;
    r.rd     = bus.ex_rd_o;
    return r;
  endfunction

  task automatic apply();
    bus.stall_i     = stall;
    bus.flush_i     = flush;
    bus.id_valid_i  = id_in.valid;
    bus.id_opcode_i = id_in.opcode;
    bus.id_funct_i  = id_in.funct;
    bus.id_aluop_i  = id_in.aluop;
    bus.id_branch_i = id_in.branch;
    bus.id_jump_i   = id_in.jump;
    bus.id_halt_i   = id_in.halt;
    bus.id_op1_i    = id_in.op1;
    bus.id_op2_i    = id_in.op2;
    bus.id_imm_i    = id_in.imm;
    bus.id_rs1_i    = id_in.rs1;
    bus.id_rs2_i    = id_in.rs2;
    bus.id_rd_i     = id_in.rd;
  endtask

  task automatic rand_id(input bit allow_halt);
    id_in.valid  = ($urandom_range(0, 3) != 0);
    id_in.opcode = 4'($urandom);
    id_in.funct  = 4'($urandom);
    id_in.aluop  = 4'($urandom);
    id_in.branch = 1'($urandom);
    id_in.jump   = 1'($urandom);
    id_in.halt   = allow_halt && ($urandom_range(0, 11) == 0);
    id_in.op1    = 16'($urandom);
    id_in.op2    = 16'($urandom);
    id_in.imm    = 16'($urandom);
    id_in.rs1    = 4'($urandom);
    id_in.rs2    = 4'($urandom);
    id_in.rd     = 4'($urandom);
    if (id_in.halt) id_in.opcode = OP_HALT;
  endtask

  // One clock edge; the model applies the stage rules to the inputs present at that edge
  task automatic tick();
    @(posedge clk);
    if (m_age >= 0) begin
      m_ex = '0;
      m_age++;
    end else if (flush) begin
      m_ex = '0;
`ifdef ID_EX_FLUSH_CNT_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end else if (!stall) begin
      m_ex = id_in;
      if (id_in.valid && id_in.halt) m_age = 0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ex"}, 80'(ex_obs()), 80'(m_ex));
    chk({tag, "_draining"}, 80'(bus.draining_o), 80'(m_age >= 0 && m_age <= 2));
    chk({tag, "_halted"}, 80'(bus.halted_o), 80'(m_age >= 3));
`ifdef ID_EX_FLUSH_CNT_EN
    chk({tag, "_flush_cnt"}, 80'(flush_cnt), 80'(m_cnt));
`endif
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    m_ex  = '0;
    m_age = -1;
`ifdef ID_EX_FLUSH_CNT_EN
    m_cnt = 0;
`endif
    #2;
    check_model(tag);
    chk({tag, "_zero_ex"}, 80'(ex_obs()), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    stall = 1'b0;
    flush = 1'b0;
    id_in = '0;
    apply();
    #3;
    reset_now("reset");

    // Pass-through
    id_in.valid  = 1'b1;
    id_in.opcode = OP_ATYPE;
    id_in.aluop  = 4'b0001;
    id_in.op1    = 16'h1234;
    id_in.op2    = 16'h00FF;
    id_in.rd     = 4'h3;
    apply();
    tick();
    check_model("pass");
    chk("pass_op1", 80'(bus.ex_op1_o), 80'(16'h1234));
    chk("pass_op2", 80'(bus.ex_op2_o), 80'(16'h00FF));
    chk("pass_rd", 80'(bus.ex_rd_o), 80'(4'h3));

    // Stall holds EX while ID changes
    stall = 1'b1;
    id_in.op1 = 16'hBEEF;
    apply();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_op1", 80'(bus.ex_op1_o), 80'(16'h1234));
      check_model("stall");
    end

    // Flush with stall gives a bubble
    flush = 1'b1;
    apply();
    tick();
    chk("flush_stall_valid", 80'(bus.ex_valid_o), 80'(0));
    chk("flush_stall_aluop", 80'(bus.ex_aluop_o), 80'(0));
    check_model("flush_stall");

    // Random traffic, no halts
    for (int k = 0; k < 300; k++) begin
      rand_id(1'b0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      apply();
      tick();
      check_model("rand");
    end

    // Halt drain with valid instructions and flush pulses following it
    rand_id(1'b0);
    id_in.valid  = 1'b1;
    id_in.halt   = 1'b1;
    id_in.opcode = OP_HALT;
    stall = 1'b0;
    flush = 1'b0;
    apply();
    tick();
    chk("E0_halt", 80'(bus.ex_halt_o), 80'(1));
    chk("E0_draining", 80'(bus.draining_o), 80'(1));
    check_model("E0");
    for (int k = 1; k <= 5; k++) begin
      rand_id(1'b0);
      id_in.valid = 1'b1;
      flush = (k % 2 == 1);
      apply();
      tick();
      chk("drain_valid", 80'(bus.ex_valid_o), 80'(0));
      chk("drain_flag", 80'(bus.draining_o), 80'(k <= 2));
      chk("halted_flag", 80'(bus.halted_o), 80'(k >= 3));
      check_model("drain");
    end

    // Reset in the middle of a drain
    reset_now("halt_reset");
    id_in.valid = 1'b1;
    id_in.halt  = 1'b1;
    id_in.opcode = OP_HALT;
    flush = 1'b0;
    apply();
    tick();
    id_in.halt = 1'b0;
    id_in.opcode = OP_BRANCH;
    apply();
    tick();
    chk("mid_drain", 80'(bus.draining_o), 80'(1));
    reset_now("mid_drain_reset");
    id_in.opcode = OP_JUMP;
    id_in.jump   = 1'b1;
    apply();
    tick();
    chk("post_reset_halted", 80'(bus.halted_o), 80'(0));
    chk("post_reset_valid", 80'(bus.ex_valid_o), 80'(1));
    check_model("post_reset");

    // Random traffic with halts; reset once a halt has fully retired
    for (int k = 0; k < 400; k++) begin
      rand_id(1'b1);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      apply();
      tick();
      check_model("rand_halt");
      if (m_age >= 4) reset_now("rand_reset");
    end

`ifdef ID_EX_FLUSH_CNT_EN
    reset_now("cnt_reset");
    stall = 1'b0;
    flush = 1'b1;
    apply();
    for (int k = 0; k < 5; k++) tick();
    chk("cnt_five", 80'(flush_cnt), 80'(16'd5));
    for (int k = 0; k < 65530; k++) tick();
    chk("cnt_max", 80'(flush_cnt), 80'(16'hFFFF));
    for (int k = 0; k < 3; k++) tick();
    chk("cnt_saturate", 80'(flush_cnt), 80'(16'hFFFF));
    check_model("cnt");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the 5-stage pipelined datapath. It captures the ID-stage control outputs (ALUOP, Branch, Jump, Halt), the raw opcode and function code, register operands and addresses, and presents them to EX one cycle later. Downstream stages re-decode WB control (RegWrite, WriteOP2) from the carried opcode and function code. The block also inserts bubbles on stall or flush and runs the halt-drain sequencer, which freezes the front end once a HALT reaches EX and flags `halted_o` after that instruction retires.

## Interface
- `DATA_W`, 16, operand/immediate width
- `REG_ADDR_W`, 4, register-file address width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `stall_i`  in  1  hazard stall; hold EX outputs
- `flush_i`  in  1  branch/jump flush; load bubble
- `id_valid_i`  in  1  ID holds a real instruction
- `id_opcode_i`, `id_funct_i`  in  4 each  raw opcode / function code
- `id_aluop_i`  in  4  ALU operation from control unit
- `id_branch_i`, `id_jump_i`, `id_halt_i`  in  1 each  control-unit flags
- `id_op1_i`, `id_op2_i`, `id_imm_i`  in  DATA_W each  operands, sign-extended immediate
- `id_rs1_i`, `id_rs2_i`, `id_rd_i`  in  REG_ADDR_W each  source/destination addresses
- `ex_*_o`  out  (same widths)  registered copies of every `id_*_i` above, including `ex_valid_o`
- `draining_o`  out  1  halt in flight; front end must freeze
- `halted_o`  out  1  halt retired; sticky until reset
- `flush_cnt_o`  out  16  flush-bubble count (only with macro)

## Operation
- Per-edge priority: halt state (DRAIN/HALTED) > `flush_i` > `stall_i` > normal load.
- Normal load: every `ex_*_o` takes its `id_*_i` value.
- Bubble: `ex_valid_o`=0. All control, opcode, funct, aluop and address outputs are 0. Data outputs are 0.
- Stall: all `ex_*_o` hold their values. Flush with stall asserted in the same cycle loads a bubble.
- Halt FSM states:
  - RUN: normal. On an edge that loads `id_valid_i`=1 and `id_halt_i`=1, go to DRAIN with drain count = 2. The halt instruction itself is loaded into EX on that edge.
  - DRAIN: load a bubble every edge regardless of `stall_i`/`flush_i`/ID inputs. Decrement count each edge. From count 0, the next edge goes to HALTED.
  - HALTED: load a bubble every edge; terminal until reset.
- A halt loaded with `id_valid_i`=0 is ignored; a bubble never triggers DRAIN.
- `draining_o` = state DRAIN. `halted_o` = state HALTED. Both are registered.
- Reset, including mid-drain: state RUN, count 0, every output 0, `flush_cnt_o` 0.

## Timing
- Latency: 1 cycle, ID input to EX output. No combinational input-to-output path.
- Halt: captured at edge E0 (`ex_halt_o`=1, `draining_o`=1). E1 and E2 load bubbles. At E3, `halted_o`=1 and `draining_o`=0. This aligns with the halt leaving WB.
- `stall_i`/`flush_i` are sampled at the same edge as the ID data. An upstream stall reaction to `draining_o` takes effect no earlier than E1.

## Configuration
- `ID_EX_FLUSH_CNT_EN` defined:
  - `flush_cnt_o` is present.
  - It increments on each RUN-state edge where `flush_i`=1.
  - It saturates at 16'hFFFF.
  - It is reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared `pipeline_pkg`:
  - opcode constants (A-type 4'b0001, HALT, branch, jump)
  - halt-FSM state encoding (RUN, DRAIN, HALTED)
  - the ID/EX control bundle typedef, also used by EX/MEM
- Sub-module `halt_drain_fsm`:
  - inputs: `clk`, `rst_n`, load-halt strobe
  - outputs: `draining_o`, `halted_o`, force-bubble
- The register bank stays in `id_ex_stage_reg`.

## Test plan
- Reset mid-drain: assert `rst_n`=0 during DRAIN. All outputs read 0 with no clock edge. After release, state is RUN and `halted_o`=0.
- Pass-through: `id_valid_i`=1, aluop=4'b0001, op1=16'h1234, op2=16'h00FF, rd=4'h3. The next edge gives identical `ex_*_o` values.
- Stall hold: `stall_i`=1 for 2 cycles while ID inputs change to op1=16'hBEEF. `ex_op1_o` stays 16'h1234.
- Flush plus stall in the same cycle: the result is a bubble (`ex_valid_o`=0, `ex_aluop_o`=0).
- Halt drain: valid halt loaded at E0, with further valid ID instructions applied afterwards.
  - `draining_o` is high E0–E2 and `halted_o` rises at E3.
  - `ex_valid_o`=0 from E1 onward.
  - `flush_i` pulses during DRAIN have no effect.
- Counter (macro on): 5 flush cycles give `flush_cnt_o`=5. Forcing the count to 16'hFFFF and flushing again keeps it at 16'hFFFF.
